// File: rtl/noc_pkg.sv
// Shared flit layout and framer state encoding for the NoC input receiver.
package noc_pkg;

  localparam int FLIT_DATA_W   = 32;
  // Control bits sit above the payload: {tail, head, data}.
  localparam int FLIT_CTRL_W   = 2;
  localparam int FLIT_HEAD_OFS = 0;
  localparam int FLIT_TAIL_OFS = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } framer_state_t;

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with a show-ahead head entry; empty reads return zero.
module flit_fifo #(
  parameter int WIDTH = noc_pkg::FLIT_DATA_W + noc_pkg::FLIT_CTRL_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Masking keeps the data outputs at zero whenever nothing is stored.
  assign rdata = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/flit_receiver.sv
// NoC input port: packet framer that drops orphan flits, feeding a flit FIFO,
// with packet and framing-error counters.
module flit_receiver
  import noc_pkg::*;
#(
  parameter int DATA_W = FLIT_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_head,
  input  logic                   in_tail,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_head,
  output logic                   out_tail,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   in_packet,
  output logic                   frame_err,
  output logic [15:0]            pkt_count,
  output logic [7:0]             err_count
);

  localparam int FW = DATA_W + FLIT_CTRL_W;

  framer_state_t state_reg;
  framer_state_t state_next;
  logic          ready_en_reg;
  logic          frame_err_reg;
  logic [15:0]   pkt_count_reg;
  logic [7:0]    err_count_reg;
  logic          accept;
  logic          pop;
  logic          write_en;
  logic          err_event;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] wdata;
  logic [FW-1:0] rdata;

  // ready_en holds in_ready low until the first edge after reset release.
  assign in_ready  = ready_en_reg && !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_packet = (state_reg == ST_BODY);
  assign frame_err = frame_err_reg;
  assign pkt_count = pkt_count_reg;
  assign err_count = err_count_reg;

  always_comb begin
    wdata                          = '0;
    wdata[DATA_W-1:0]              = in_data;
    wdata[DATA_W + FLIT_HEAD_OFS]  = in_head;
    wdata[DATA_W + FLIT_TAIL_OFS]  = in_tail;
  end

  assign out_data = rdata[DATA_W-1:0];
  assign out_head = rdata[DATA_W + FLIT_HEAD_OFS];
  assign out_tail = rdata[DATA_W + FLIT_TAIL_OFS];

  always_comb begin
    state_next = state_reg;
    write_en   = 1'b0;
    err_event  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (in_head) begin
            write_en = 1'b1;
            if (!in_tail) begin
              state_next = ST_BODY;
            end
          end else begin
            err_event = 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (accept) begin
          // A head here restarts the packet; the unterminated one is flagged.
          write_en  = 1'b1;
          err_event = in_head;
          if (in_tail) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      ready_en_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      pkt_count_reg <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ready_en_reg  <= 1'b1;
      frame_err_reg <= err_event;
      if (write_en && in_tail) begin
        pkt_count_reg <= pkt_count_reg + 16'd1;
      end
      if (err_event && (err_count_reg != 8'hFF)) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  flit_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (write_en),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

endmodule

// File: doc/flit_receiver.md
FLIT_RECEIVER -- requirements
Module: flit_receiver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning flit payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_data, input, DATA_W, flit payload from the upstream switch.
REQ-006 The block SHALL have port in_valid, input, 1, upstream flit valid.
REQ-007 The block SHALL have port in_ready, output, 1, the receiver can accept a flit this cycle.
REQ-008 The block SHALL have ports in_head and in_tail, input, 1 each, first-flit and last-flit markers.
REQ-009 The block SHALL have port out_data, output, DATA_W, buffered flit toward the local VC/switch stage.
REQ-010 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_head (output, 1) and out_tail (output, 1), downstream handshake and markers.
REQ-011 The block SHALL have port occupancy, output, clog2(DEPTH)+1, number of stored flits.
REQ-012 The block SHALL have port in_packet, output, 1, high while the framer is inside a packet.
REQ-013 The block SHALL have port frame_err, output, 1, one-cycle pulse on a framing violation.
REQ-014 The block SHALL have ports pkt_count (output, 16), tails written and wrapping, and err_count (output, 8), framing errors and saturating at 255.

Function
REQ-015 Handshake: in_ready SHALL equal (occupancy < DEPTH), combinational from state only and never from in_valid; a flit is accepted when in_valid && in_ready.
REQ-016 Storage: an accepted, non-dropped flit SHALL be written as {tail, head, data}, becoming visible on out_* one cycle after acceptance (no combinational bypass).
REQ-017 Output: out_valid SHALL equal (occupancy != 0); out_data/out_head/out_tail SHALL show the oldest entry; a pop occurs when out_valid && out_ready.
REQ-018 out_* SHALL hold stable while out_valid && !out_ready.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-020 When full, in_ready SHALL be low even if a pop occurs that cycle; there is no full-cycle bypass.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 Framer FSM states SHALL be IDLE and BODY.
REQ-023 IDLE with accepted head=1, tail=0: write the flit, go to BODY.
REQ-024 IDLE with accepted head=1, tail=1: write the flit, stay IDLE, increment pkt_count.
REQ-025 IDLE with accepted head=0 (orphan): drop the flit (it is still handshaken), pulse frame_err, stay IDLE.
REQ-026 BODY with accepted head=0, tail=0: write the flit, stay BODY.
REQ-027 BODY with accepted head=0, tail=1: write the flit, go to IDLE, increment pkt_count.
REQ-028 BODY with accepted head=1 (missing tail): write the flit as a new packet start, pulse frame_err; go to IDLE if tail=1, otherwise stay BODY.
REQ-029 in_packet SHALL equal (state == BODY).
REQ-030 frame_err SHALL be registered, high for exactly the cycle after the offending acceptance.
REQ-031 err_count SHALL increment on each frame_err event and saturate at 255.
REQ-032 pkt_count SHALL wrap from 65535 to 0.

Reset
REQ-033 While reset is low, the block SHALL hold: occupancy=0, pointers=0, out_valid=0, in_ready=0, state=IDLE, frame_err=0, pkt_count=0, err_count=0, out_data/out_head/out_tail=0.
REQ-034 Assertion mid-packet or with a non-empty FIFO SHALL discard all contents immediately (asynchronously).
REQ-035 in_ready SHALL rise in the first clock edge after deassertion.
REQ-036 Deassertion SHALL be treated as synchronous to clk.

Structure
REQ-037 The shared package noc_pkg SHALL hold the flit width constant, the flit field positions {tail, head, data}, and the framer state encoding.
REQ-038 Storage SHALL be the sub-module flit_fifo (parameterised DATA_W+2, DEPTH) with push, pop, full, empty and count.
REQ-039 The framer FSM and counters SHALL reside in flit_receiver.

Verification
REQ-040 Single-flit packet head=1,tail=1, data=0xA5A5A5A5 -> out_valid the next cycle with the same data, head=1, tail=1; pkt_count=1; frame_err never pulses.
REQ-041 4-flit packet with out_ready=0 -> in_ready drops after the 4th accept, occupancy=4; then set out_ready=1 -> flits drain in order with the markers intact.
REQ-042 Body flit 0x1 while IDLE -> no write, occupancy stays 0, frame_err pulses once, err_count=1.
REQ-043 head(0x10), body(0x11), head+tail(0x20) -> all three written, frame_err pulses once, final state IDLE, pkt_count=1.
REQ-044 Reset asserted with 3 flits stored and state BODY -> out_valid=0 and occupancy=0 immediately; after release a head flit is accepted normally.
REQ-045 Continuous streaming with in_valid=1 and out_ready=1 for 300 packets, DEPTH=4 -> occupancy stays at 1 or below, pkt_count=300, and err_count stays 0 over a separately forced run of 260 orphan flits ending at 255.
